// File: rtl/serv_dbus_pkg.sv
// rtl/serv_dbus_pkg.sv - shared FSM encoding, size codes and counter sizing for the SERV bus interfaces
package serv_dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Wait counter must hold TIMEOUT itself; a disabled timeout still gets one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    if (timeout == 0) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/serv_dbus_lane.sv
// rtl/serv_dbus_lane.sv - byte-enable and misalignment decode from access size and address low bits
module serv_dbus_lane
  import serv_dbus_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_adr_lo,
  output logic [3:0] o_sel,
  output logic       o_misalign
);

  always_comb begin
    o_sel      = 4'b1111;
    o_misalign = 1'b0;
    case (i_size)
      SIZE_BYTE: begin
        o_sel      = 4'b0001 << i_adr_lo;
        o_misalign = 1'b0;
      end
      SIZE_HALF: begin
        o_sel      = 4'b0011 << i_adr_lo;
        o_misalign = i_adr_lo[0];
      end
      // Size code 11 behaves exactly like a word access.
      default: begin
        o_sel      = 4'b1111;
        o_misalign = |i_adr_lo;
      end
    endcase
  end

endmodule

// File: rtl/serv_dbus_if.sv
// rtl/serv_dbus_if.sv - SERV data-bus master: request latch, single-beat bus cycle, wait-cycle timeout
module serv_dbus_if
  import serv_dbus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_load,
  output logic [31:0] o_rdt,
  output logic        o_misalign,
  output logic        o_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_rdt
);

  localparam int unsigned    CW         = wait_cnt_width(TIMEOUT);
  localparam bit             TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0]  WAIT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]  WAIT_MAX   = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          busy_q, busy_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          done_q, done_d;
  logic          load_q, load_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;

  logic [3:0]    lane_sel;
  logic          lane_mis;
  logic          timeout_hit;

  serv_dbus_lane u_lane (
    .i_size     (i_size),
    .i_adr_lo   (i_adr[1:0]),
    .o_sel      (lane_sel),
    .o_misalign (lane_mis)
  );

  // This cycle's missing ack would bring the counter up to TIMEOUT.
  assign timeout_hit = TIMEOUT_EN && (wait_q == WAIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdt_q   <= '0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      rdt_q   <= rdt_d;
      done_q  <= done_d;
      load_q  <= load_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdt_d   = rdt_q;
    done_d  = 1'b0;
    load_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          if (lane_mis) begin
            mis_d = 1'b1;
          end else begin
            adr_d   = {i_adr[31:2], 2'b00};
            dat_d   = i_dat;
            sel_d   = lane_sel;
            we_d    = i_we;
            wait_d  = '0;
            state_d = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        // Error wins over a simultaneous ack; a timeout is reported as an error.
        if (i_wb_err) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (i_wb_ack) begin
          if (!we_q) begin
            rdt_d = i_wb_rdt;
          end
          done_d  = 1'b1;
          load_d  = !we_q;
          state_d = ST_RESP;
        end else begin
          if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
          end
          if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cycle and busy flags are registered copies of the next state.
  always_comb begin
    cyc_d  = (state_d == ST_BUS);
    busy_d = (state_d != ST_IDLE);
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_load     = load_q;
  assign o_rdt      = rdt_q;
  assign o_misalign = mis_q;
  assign o_err      = err_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_we    = we_q;
  assign o_wb_cyc   = cyc_q;

endmodule

// File: tb/tb_serv_dbus_if.sv
// tb/tb_serv_dbus_if.sv - self-checking bench for serv_dbus_if
module tb_serv_dbus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, wb_ack, wb_err;
  logic [1:0]  size;
  logic [31:0] adr, dat, wb_rdt;
  logic        o_busy, o_done, o_load, o_misalign, o_err, o_wb_we, o_wb_cyc;
  logic [31:0] o_rdt, o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;

  always #5 clk = ~clk;

  serv_dbus_if #(.TIMEOUT(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_we       (we),
    .i_size     (size),
    .i_adr      (adr),
    .i_dat      (dat),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_load     (o_load),
    .o_rdt      (o_rdt),
    .o_misalign (o_misalign),
    .o_err      (o_err),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_ack   (wb_ack),
    .i_wb_err   (wb_err),
    .i_wb_rdt   (wb_rdt)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] adr;
    logic [31:0] dat;
    int          waits;
    logic [31:0] rdt;
    logic [3:0]  sel;
    logic        mis;
  } vec_t;

  typedef struct {
    logic        done;
    logic        load;
    logic        err;
    logic        mis;
    logic [31:0] rdt;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[10];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] last_rdt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (o_done || o_load || o_err || o_misalign)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {28'h0, o_done, o_load, o_err, o_misalign}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {28'h0, o_done, o_load, o_err, o_misalign},
            {28'h0, e.done, e.load, e.err, e.mis});
        if (e.load) chk("load_rdt", o_rdt, e.rdt);
      end
    end
  end

  task automatic do_txn(input vec_t v);
    exp_t        e;
    logic [31:0] wadr;
    wadr = {v.adr[31:2], 2'b00};
    if (v.mis) e = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    else       e = '{1'b1, !v.we, 1'b0, 1'b0, v.rdt};
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; we = v.we; size = v.size; adr = v.adr; dat = v.dat;
    @(posedge clk); #1;
    req = 1'b0; adr = 32'hFFFF_FFFF; dat = 32'h0;
    if (v.mis) begin
      chk("mis_no_cyc", {31'h0, o_wb_cyc}, 32'h0);
      chk("mis_not_busy", {31'h0, o_busy}, 32'h0);
      @(posedge clk); #1;
      chk("mis_no_cyc_later", {31'h0, o_wb_cyc}, 32'h0);
      return;
    end
    chk("cyc_after_req", {31'h0, o_wb_cyc}, 32'h1);
    chk("wb_adr", o_wb_adr, wadr);
    chk("wb_sel", {28'h0, o_wb_sel}, {28'h0, v.sel});
    chk("wb_we", {31'h0, o_wb_we}, {31'h0, v.we});
    chk("wb_dat", o_wb_dat, v.dat);
    for (int i = 0; i < v.waits; i++) begin
      // A request while busy must not disturb the cycle in flight.
      req = 1'b1; adr = 32'h0000_0F00; size = 2'b10;
      @(posedge clk); #1;
      chk("cyc_held", {31'h0, o_wb_cyc}, 32'h1);
      chk("adr_stable", o_wb_adr, wadr);
      chk("sel_stable", {28'h0, o_wb_sel}, {28'h0, v.sel});
    end
    req = 1'b0; wb_ack = 1'b1; wb_rdt = v.rdt;
    @(posedge clk); #1;
    wb_ack = 1'b0; wb_rdt = 32'h0;
    chk("cyc_drop_on_ack", {31'h0, o_wb_cyc}, 32'h0);
    chk("busy_in_resp", {31'h0, o_busy}, 32'h1);
    if (!v.we) last_rdt = v.rdt;
    chk("rdt_after_ack", o_rdt, last_rdt);
    @(posedge clk); #1;
    chk("idle_after_resp", {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; adr = 32'h0; dat = 32'h0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_rdt = 32'h0; last_rdt = 32'h0;

    vecs[0] = '{1'b0, 2'b10, 32'h0000_0100, 32'h0,          3, 32'hDEAD_BEEF, 4'b1111, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 32'h0000_0203, 32'hAB00_0000, 0, 32'h0,          4'b1000, 1'b0};
    vecs[2] = '{1'b0, 2'b01, 32'h0000_0301, 32'h0,          0, 32'h0,          4'b0000, 1'b1};
    vecs[3] = '{1'b0, 2'b00, 32'h0000_0101, 32'h0,          0, 32'h1234_5678, 4'b0010, 1'b0};
    vecs[4] = '{1'b1, 2'b01, 32'h0000_0402, 32'hCAFE_0000, 1, 32'h0,          4'b1100, 1'b0};
    vecs[5] = '{1'b0, 2'b01, 32'h0000_0500, 32'h0,          2, 32'h0000_BEEF, 4'b0011, 1'b0};
    vecs[6] = '{1'b1, 2'b10, 32'h0000_0603, 32'h1111_2222, 0, 32'h0,          4'b0000, 1'b1};
    vecs[7] = '{1'b0, 2'b11, 32'h0000_0700, 32'h0,          0, 32'h55AA_55AA, 4'b1111, 1'b0};
    vecs[8] = '{1'b1, 2'b11, 32'h0000_0702, 32'h3333_4444, 0, 32'h0,          4'b0000, 1'b1};
    vecs[9] = '{1'b0, 2'b00, 32'h0000_0802, 32'h0,          1, 32'h0077_0000, 4'b0100, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_pulses", {28'h0, o_done, o_load, o_err, o_misalign}, 32'h0);
    chk("rst_cyc_we", {30'h0, o_wb_cyc, o_wb_we}, 32'h0);
    chk("rst_sel", {28'h0, o_wb_sel}, 32'h0);
    chk("rst_adr", o_wb_adr, 32'h0);
    chk("rst_dat", o_wb_dat, 32'h0);
    chk("rst_rdt", o_rdt, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // No ack: four bus cycles, then an error pulse.
    sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 2'b10; adr = 32'h0000_0900;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (o_wb_cyc && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_cyc_cycles", n, 32'd4);
    chk("timeout_idle", {31'h0, o_busy}, 32'h0);
    do_txn('{1'b0, 2'b10, 32'h0000_0904, 32'h0, 2, 32'hA5A5_0001, 4'b1111, 1'b0});

    // Ack and error together: error only, read data not captured.
    sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 2'b10; adr = 32'h0000_0A00;
    @(posedge clk); #1;
    req = 1'b0;
    chk("both_cyc", {31'h0, o_wb_cyc}, 32'h1);
    wb_ack = 1'b1; wb_err = 1'b1; wb_rdt = 32'h9999_9999;
    @(posedge clk); #1;
    wb_ack = 1'b0; wb_err = 1'b0; wb_rdt = 32'h0;
    chk("both_cyc_drop", {31'h0, o_wb_cyc}, 32'h0);
    chk("both_idle", {31'h0, o_busy}, 32'h0);
    chk("both_rdt_kept", o_rdt, last_rdt);

    // Ack and error while idle are ignored.
    @(posedge clk); #1;
    wb_ack = 1'b1; wb_err = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wb_ack = 1'b0; wb_err = 1'b0;
    chk("idle_ack_ignored", {30'h0, o_busy, o_wb_cyc}, 32'h0);

    // Reset mid-transfer drops the cycle at once; nothing completes afterwards.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 2'b10; adr = 32'h0000_0B00;
    @(posedge clk); #1;
    req = 1'b0;
    chk("pre_rst_cyc", {31'h0, o_wb_cyc}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", {31'h0, o_wb_cyc}, 32'h0);
    chk("rst_async_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_async_adr", o_wb_adr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wb_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_cyc", {31'h0, o_wb_cyc}, 32'h0);
    chk("post_rst_rdt", o_rdt, 32'h0);
    last_rdt = 32'h0;
    do_txn('{1'b0, 2'b10, 32'h0000_0C00, 32'h0, 0, 32'h0BAD_F00D, 4'b1111, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
